// File: rtl/gate_reduce_pipe.sv
// Multi-beat bitwise reduction (AND/OR/XOR/NAND) with a registered, back-pressured result.
// Optional frame counter is enabled by defining GATE_FRAME_CNT_EN.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// ACCUM | mid-frame; accumulator holds the partial result under op_q

module gate_reduce_pipe #(
    parameter int WIDTH = 8,
    parameter int NIN   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NIN*WIDTH-1:0] A,
    input  logic [1:0]           op,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     Z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           frame_cnt
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [1:0]       cur_op;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] red;
    logic [WIDTH-1:0] folded;
    logic [WIDTH-1:0] final_val;
    logic             accept;
    logic             deliver;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !rst;
    assign deliver  = out_valid && out_ready && !rst;

    // The first beat of a frame uses the live op; later beats use the latched one.
    assign cur_op = (state_q == IDLE) ? op : op_q;

    always_comb begin
        red = A[WIDTH-1:0];
        for (int k = 1; k < NIN; k++) begin
            case (cur_op)
                2'd1:    red = red | A[k*WIDTH +: WIDTH];
                2'd2:    red = red ^ A[k*WIDTH +: WIDTH];
                default: red = red & A[k*WIDTH +: WIDTH];
            endcase
        end
    end

    always_comb begin
        folded = red;
        if (state_q == ACCUM) begin
            case (op_q)
                2'd1:    folded = acc_q | red;
                2'd2:    folded = acc_q ^ red;
                default: folded = acc_q & red;
            endcase
        end
        final_val = (cur_op == 2'd3) ? ~folded : folded;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = in_last ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            op_q      <= 2'd0;
            Z         <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept && state_q == IDLE) begin
                op_q <= op;
            end
            if (accept && !in_last) begin
                acc_q <= folded;
            end
            // A last beat accepted alongside a delivery reloads Z and keeps out_valid high.
            if (accept && in_last) begin
                Z         <= final_val;
                out_valid <= 1'b1;
            end else if (deliver) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef GATE_FRAME_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'h00;
        end else if (deliver) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign frame_cnt = cnt_q;
`else
    assign frame_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Directed self-checking bench for gate_reduce_pipe (WIDTH=8, NIN=4).
// Frame-counter expectations follow GATE_FRAME_CNT_EN.

module tb_gate_reduce_pipe;

    localparam int WIDTH = 8;
    localparam int NIN   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NIN*WIDTH-1:0] A;
    logic [1:0]           op;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [WIDTH-1:0]     Z;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           frame_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    localparam logic [31:0] OPS1 = {8'hF7, 8'h3C, 8'h0F, 8'hFF};

    gate_reduce_pipe #(.WIDTH(WIDTH), .NIN(NIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .op        (op),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .Z         (Z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] o, input logic [31:0] a, input logic last);
        op       = o;
        A        = a;
        in_last  = last;
        in_valid = 1'b1;
    endtask

    function automatic logic [7:0] exp_fc();
`ifdef GATE_FRAME_CNT_EN
        return exp_cnt[7:0];
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        rst = 1'b1; A = '0; op = 2'd0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_z", Z, 8'h00);
        check("rst_ov", out_valid, 1'b0);
        check("rst_fc", frame_cnt, 8'h00);
        check("rst_ir", in_ready, 1'b1);

        // AND single beat, then hold under backpressure
        beat(2'd0, OPS1, 1'b1);
        tick();
        in_valid = 1'b0;
        check("and_z", Z, 8'h04);
        check("and_ov", out_valid, 1'b1);
        check("and_ir_bp", in_ready, 1'b0);
        tick();
        check("and_hold_z", Z, 8'h04);
        check("and_hold_ov", out_valid, 1'b1);
        out_ready = 1'b1;
        tick(); exp_cnt++;
        check("and_dlv_ov", out_valid, 1'b0);
        check("and_dlv_fc", frame_cnt, exp_fc());

        // NAND single beat
        beat(2'd3, OPS1, 1'b1);
        tick();
        in_valid = 1'b0;
        check("nand_z", Z, 8'hFB);
        check("nand_ov", out_valid, 1'b1);
        tick(); exp_cnt++;
        check("nand_dlv_ov", out_valid, 1'b0);

        // NAND two beats; op change on beat 2 must be ignored
        beat(2'd3, OPS1, 1'b0);
        tick();
        check("nand2_mid_ov", out_valid, 1'b0);
        beat(2'd1, 32'hFFFF_FFFF, 1'b1);
        tick();
        in_valid = 1'b0;
        check("nand2_z", Z, 8'hFB);
        tick(); exp_cnt++;

        // XOR two beats, delivered exactly once
        beat(2'd2, {8'h08, 8'h04, 8'h02, 8'h01}, 1'b0);
        tick();
        check("xor_mid_ov", out_valid, 1'b0);
        beat(2'd0, {8'h00, 8'h00, 8'h00, 8'hF0}, 1'b1);
        tick();
        in_valid = 1'b0;
        check("xor_z", Z, 8'hFF);
        check("xor_ov", out_valid, 1'b1);
        tick(); exp_cnt++;
        check("xor_once_ov", out_valid, 1'b0);
        check("xor_fc", frame_cnt, exp_fc());

        // Backpressure then simultaneous delivery and reload
        out_ready = 1'b0;
        beat(2'd0, OPS1, 1'b1);
        tick();
        check("bp_z0", Z, 8'h04);
        beat(2'd1, {8'h00, 8'h00, 8'h00, 8'h55}, 1'b1);
        #1;
        check("bp_ir", in_ready, 1'b0);
        tick();
        check("bp_hold_z", Z, 8'h04);
        check("bp_hold_ov", out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        check("bp_ir_up", in_ready, 1'b1);
        tick(); exp_cnt++;
        in_valid = 1'b0;
        check("reload_z", Z, 8'h55);
        check("reload_ov", out_valid, 1'b1);
        check("reload_fc", frame_cnt, exp_fc());
        tick(); exp_cnt++;
        check("reload_dlv_ov", out_valid, 1'b0);

        // Reset mid-frame discards the partial OR frame
        beat(2'd1, {8'h00, 8'h00, 8'h00, 8'h80}, 1'b0);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick(); exp_cnt = 0;
        check("mrst_fc", frame_cnt, 8'h00);
        beat(2'd1, {8'h00, 8'h00, 8'h00, 8'h7E}, 1'b1);
        tick();
        check("mrst_noacc_ov", out_valid, 1'b0);
        rst = 1'b0;
        beat(2'd1, {8'h00, 8'h00, 8'h00, 8'h01}, 1'b1);
        tick();
        in_valid = 1'b0;
        check("mrst_z", Z, 8'h01);
        check("mrst_ov", out_valid, 1'b1);
        tick(); exp_cnt++;

        // Counter wrap over 256 deliveries
        rst = 1'b1;
        tick();
        rst = 1'b0; exp_cnt = 0;
        check("wrap_start_fc", frame_cnt, 8'h00);
        for (int i = 1; i <= 256; i++) begin
            beat(2'd0, OPS1, 1'b1);
            tick();
            in_valid = 1'b0;
            tick(); exp_cnt++;
            if (i == 255) check("wrap_255_fc", frame_cnt, exp_fc());
        end
        check("wrap_256_fc", frame_cnt, exp_fc());
        check("wrap_ov", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_reduce_pipe.md
GATE_REDUCE_PIPE -- requirements
Module: gate_reduce_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each operand and of the result.
REQ-002 SHALL have parameter NIN, default 4: number of operands per beat, legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port A, input, NIN*WIDTH bits: packed operands, with operand k at bits [k*WIDTH +: WIDTH].
REQ-006 SHALL have port op, input, 2 bits: operation select, 0=AND, 1=OR, 2=XOR, 3=NAND.
REQ-007 SHALL have port in_valid, input, 1 bit: beat on A/op/in_last is valid.
REQ-008 SHALL have port in_last, input, 1 bit: the beat is the final beat of its frame.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 SHALL have port Z, output, WIDTH bits: registered frame result.
REQ-011 SHALL have port out_valid, output, 1 bit: Z holds an unconsumed result.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts Z this cycle.
REQ-013 SHALL have port frame_cnt, output, 8 bits: count of delivered frames.

Function
REQ-014 SHALL define a beat as accepted when in_valid && in_ready, and a result as delivered when out_valid && out_ready.
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally, for every beat.
REQ-016 SHALL compute the beat reduction R as the bitwise AND, OR or XOR of all NIN operands; op 3 SHALL use AND internally.
REQ-017 SHALL implement an FSM with states IDLE and ACCUM.
REQ-018 SHALL, in IDLE, latch op into an op register on each accepted beat; op SHALL be ignored on later beats of the same frame.
REQ-019 SHALL, on an accepted beat in IDLE with in_last=0, load the accumulator with R and move to ACCUM.
REQ-020 SHALL, on an accepted beat in ACCUM with in_last=0, fold R into the accumulator using the latched operation and stay in ACCUM.
REQ-021 SHALL, on an accepted beat with in_last=1, load Z with the final value (R in IDLE, accumulator folded with R in ACCUM), set out_valid, and go to IDLE.
REQ-022 SHALL bitwise-invert the final value before loading Z when the latched op is 3.
REQ-023 SHALL produce Z one cycle after the last beat is accepted, giving one-cycle latency for single-beat frames.
REQ-024 SHALL hold Z and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL clear out_valid on delivery unless a last beat is accepted in the same cycle, in which case Z SHALL reload and out_valid SHALL stay 1.
REQ-026 SHALL make Z equal to operand 0 when NIN=1 and the op is AND, OR or XOR.
REQ-027 SHALL increment frame_cnt by 1 on each delivery, wrapping from 255 to 0.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, force FSM=IDLE, accumulator=0, op register=0, Z=0, out_valid=0 and frame_cnt=0.
REQ-029 SHALL, on reset asserted mid-frame, discard the partial frame so that the first beat after reset starts a new frame.
REQ-030 SHALL accept no beat and deliver no result in any cycle where rst=1.

Configuration
REQ-031 SHALL, with macro GATE_FRAME_CNT_EN defined, implement frame_cnt as specified in REQ-027.
REQ-032 SHALL, with GATE_FRAME_CNT_EN undefined, tie frame_cnt to 8'h00 and contain no counter register; all other behaviour SHALL be unchanged.

Verification (WIDTH=8, NIN=4, operands listed 0..3)
REQ-033 SHALL test AND, single beat: A=FF,0F,3C,F7 with in_last=1 -> next cycle Z=04, out_valid=1.
REQ-034 SHALL test NAND, single beat: same operands with op=3 -> Z=FB; an op change on a following beat of a multi-beat frame SHALL not alter the result.
REQ-035 SHALL test XOR, two-beat frame: beat 1 = 01,02,04,08 (last=0), then beat 2 = F0,00,00,00 (last=1) -> Z=FF exactly once.
REQ-036 SHALL test backpressure: with out_valid=1 and out_ready=0 -> in_ready=0 and Z holds; raising out_ready with a last beat pending -> delivery and reload in the same cycle, out_valid stays 1.
REQ-037 SHALL test reset mid-frame: an OR beat of 80,00,00,00 (last=0), then rst, then OR 01,00,00,00 (last=1) -> Z=01.
REQ-038 SHALL test counter wrap: 256 delivered frames -> frame_cnt=00, with frame_cnt=FF after frame 255; with GATE_FRAME_CNT_EN undefined -> frame_cnt=00 throughout.
